// File: rtl/fetch_unit.sv
// fetch_unit: PC generation + instruction fetch feeding a 2-entry {pc, instr} queue to decode.
// Latency: instruction fetched at edge N is on out_* in the following cycle; redirect-to-valid = 2 cycles.
// Backpressure: out_ready=0 lets the queue fill to 2, then PC holds; enqueue+dequeue when full is allowed.
// Ports: clock/reset (async active-low); fetch_enable; imem_addr/imem_data (combinational memory);
//        redirect_valid/redirect_target; out_valid/out_instr/out_pc/out_ready (decode handshake);
//        fault (sticky misaligned redirect), busy (fetching state).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          QDEPTH     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault,
  output logic        busy
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] qpc_q  [2];
  logic [31:0] qins_q [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  logic run_st;
  logic deq, can_enq, flush;
  logic redir_live, redir_ok, redir_bad;
  logic pc_in_range, tgt_in_range;

  // A fault is terminal, so redirects are ignored once in it.
  assign redir_live   = redirect_valid && (state_q != S_FAULT);
  assign redir_ok     = redir_live && (redirect_target[1:0] == 2'b00);
  assign redir_bad    = redir_live && (redirect_target[1:0] != 2'b00);
  assign flush        = redir_live;
  assign pc_in_range  = pc_q < PC_LIMIT;
  assign tgt_in_range = redirect_target < PC_LIMIT;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = out_valid ? qpc_q[head_q]  : 32'h0;
  assign out_instr = out_valid ? qins_q[head_q] : 32'h0;

  assign deq = out_valid & out_ready;
  // Room exists if not full, or if the head leaves this same cycle.
  assign can_enq = run_st & fetch_enable & pc_in_range & ~redirect_valid &
                   ((count_q < 2'(QDEPTH)) | deq);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == S_FAULT) begin
      state_d = S_FAULT;
    end else if (redir_bad) begin
      state_d = S_FAULT;
    end else if (redir_ok) begin
      // An IDLE unit only takes the new PC; it starts fetching on fetch_enable.
      if (state_q != S_IDLE) state_d = tgt_in_range ? S_RUN : S_DONE;
    end else begin
      case (state_q)
        S_IDLE:  if (fetch_enable) state_d = S_RUN;
        S_RUN: begin
          if (!pc_in_range)       state_d = S_DONE;
          else if (!fetch_enable) state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run_st = (state_q == S_RUN);
    busy   = (state_q == S_RUN);
    fault  = (state_q == S_FAULT);
  end

  // ---------------- PC and queue pointers ----------------
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redir_ok)     pc_d = redirect_target;
    else if (can_enq) pc_d = pc_q + 32'd4;
    if (flush) begin
      // A same-cycle dequeue is still discarded along with everything else.
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (can_enq) tail_d = ~tail_q;
      if (deq)     head_d = ~head_q;
      count_d = count_q + {1'b0, can_enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      qpc_q[0]  <= 32'h0;
      qpc_q[1]  <= 32'h0;
      qins_q[0] <= 32'h0;
      qins_q[1] <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (can_enq) begin
        qpc_q[tail_q]  <= pc_q;
        qins_q[tail_q] <= imem_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] LIMIT = 32'h80;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_enable = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        fault;
  logic        busy;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fault          (fault),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Instruction memory: mem[addr/4] = addr + 0x100.
  assign imem_data = imem_addr + 32'h100;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  int          m_mode;

  task automatic model_reset();
    m_pc   = 32'h0;
    m_q    = {};
    m_mode = M_IDLE;
  endtask

  task automatic model_step();
    logic [31:0] old_pc;
    logic [31:0] tmp;
    bit          deq;
    deq = (m_q.size() > 0) && out_ready;
    if (m_mode == M_FAULT) return;
    if (redirect_valid) begin
      m_q = {};
      if (redirect_target[1:0] != 2'b00) begin
        m_mode = M_FAULT;
      end else begin
        m_pc = redirect_target;
        if (m_mode != M_IDLE) m_mode = (redirect_target < LIMIT) ? M_RUN : M_DONE;
      end
      return;
    end
    if (deq) tmp = m_q.pop_front();
    old_pc = m_pc;
    if (m_mode == M_RUN && fetch_enable && old_pc < LIMIT && m_q.size() < 2) begin
      m_q.push_back(old_pc);
      m_pc = old_pc + 32'd4;
    end
    if (m_mode == M_IDLE) begin
      if (fetch_enable) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (old_pc >= LIMIT)    m_mode = M_DONE;
      else if (!fetch_enable) m_mode = M_IDLE;
    end
  endtask

  task automatic check_model();
    bit v;
    v = m_q.size() > 0;
    chk("m_out_valid", 32'(out_valid), 32'(v));
    if (v) begin
      chk("m_out_pc", out_pc, m_q[0]);
      chk("m_out_instr", out_instr, m_q[0] + 32'h100);
    end
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_fault", 32'(fault), 32'(m_mode == M_FAULT));
    chk("m_busy", 32'(busy), 32'(m_mode == M_RUN));
  endtask

  // ---------------- stimulus helpers ----------------
  // drive: apply inputs right after a rising edge, then sample at the falling edge.
  task automatic drive(input logic fe, input logic rv, input logic [31:0] rt, input logic rdy);
    fetch_enable    = fe;
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
    @(negedge clock);
    check_model();
  endtask

  task automatic adv();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic fe, input logic rv, input logic [31:0] rt, input logic rdy);
    drive(fe, rv, rt, rdy);
    adv();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] last_pc;
    int          fault_age;
    logic [31:0] rt;
    int          r;

    // Startup with backpressure: out_ready low for the 4 cycles after first valid.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h04, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h08, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h08, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h00, 32'h08, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h08, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h0C, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h10, 1'b1};

    model_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].fe, 1'b0, 32'h0, tbl[i].rdy);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk("tbl_pc", out_pc, tbl[i].exp_pc);
        chk("tbl_instr", out_instr, tbl[i].exp_pc + 32'h100);
      end
      chk("tbl_addr", imem_addr, tbl[i].exp_addr);
      chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      adv();
    end

    // Redirect to 0x40 with 0x10,0x14 queued: both discarded, 0x40 two cycles later.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    chk("redir_pre_pc", out_pc, 32'h10);
    chk("redir_pre_valid", 32'(out_valid), 32'h1);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_r1_valid", 32'(out_valid), 32'h0);
    chk("redir_r1_addr", imem_addr, 32'h40);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_r2_valid", 32'(out_valid), 32'h1);
    chk("redir_r2_pc", out_pc, 32'h40);
    chk("redir_r2_instr", out_instr, 32'h140);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_r3_pc", out_pc, 32'h44);
    adv();

    // Asynchronous reset mid-cycle with a full queue.
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("areset_pre_valid", 32'(out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_valid", 32'(out_valid), 32'h0);
    chk("areset_addr", imem_addr, 32'h0);
    chk("areset_busy", 32'(busy), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();

    // Misaligned redirect: sticky fault, PC frozen, later redirects ignored.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 1), 32'h0, 1'b1);
      chk("fault_flag", 32'(fault), 32'h1);
      chk("fault_valid", 32'(out_valid), 32'h0);
      chk("fault_addr", imem_addr, 32'h0C);
      chk("fault_busy", 32'(busy), 32'h0);
      adv();
    end
    do_reset();

    // Run to the end of memory, then redirect back to 0.
    last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid) last_pc = out_pc;
      adv();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("done_last_pc", last_pc, 32'h7C);
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_valid", 32'(out_valid), 32'h0);
    chk("done_addr", imem_addr, 32'h80);
    adv();
    drive(1'b1, 1'b1, 32'h0, 1'b1);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("resume_addr", imem_addr, 32'h0);
    chk("resume_busy", 32'(busy), 32'h1);
    adv();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("resume_valid", 32'(out_valid), 32'h1);
    chk("resume_pc", out_pc, 32'h0);
    adv();

    // Randomized traffic against the reference model.
    fault_age = 0;
    for (int i = 0; i < 1500; i++) begin
      if (fault_age > 4 || $urandom_range(0, 299) == 0) begin
        do_reset();
        fault_age = 0;
      end
      r = $urandom_range(0, 9);
      if (r == 0)      rt = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(1, 3));
      else if (r == 1) rt = 32'h80 + 32'($urandom_range(0, 15) * 4);
      else             rt = 32'($urandom_range(0, 31) * 4);
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0), rt,
          ($urandom_range(0, 2) != 0));
      if (m_mode == M_FAULT) fault_age++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
